// File: rtl/mfp_hex_serial_display_driver.sv
// Hex display driver for a chained 74HC595 pair: decodes one digit per
// frame, shifts {seg,sel} MSB-first, latches, and holds before the next.
module mfp_hex_serial_display_driver #(
  parameter int N_DIGITS       = 8,
  parameter int CLK_DIV        = 8,
  parameter int HOLD_CYCLES    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] hex,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic                  enable,
  output logic                  sclk,
  output logic                  sdo,
  output logic                  rclk,
  output logic [2:0]            digit
);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, HOLD} state_t;

  localparam int MAXC = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int HW   = 4 * N_DIGITS;

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    DIG_LAST  = 3'(N_DIGITS - 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [3:0]      bit_cnt, bit_d;
  logic [15:0]     frame, frame_d;
  logic [HW-1:0]   hex_sh;
  logic [N_DIGITS-1:0] dots_sh;
  logic            en_sh;
  logic            snap;
  logic            sclk_d, sdo_d, rclk_d;
  logic [2:0]      digit_d;

  logic [31:0]     hex_pad;
  logic [7:0]      dots_pad;
  logic            en_eff;
  logic [3:0]      nib;
  logic [7:0]      seg_raw, seg_byte, sel_byte;
  logic [15:0]     frame_new;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit 0 reads the live inputs so the frame matches the snapshot taken
  // in that same LOAD cycle.
  always_comb begin
    hex_pad  = '0;
    dots_pad = '0;
    en_eff   = en_sh;
    hex_pad[HW-1:0]        = hex_sh;
    dots_pad[N_DIGITS-1:0] = dots_sh;
    if (digit == 3'd0) begin
      hex_pad[HW-1:0]        = hex;
      dots_pad[N_DIGITS-1:0] = dots;
      en_eff                 = enable;
    end
    nib       = hex_pad[{digit, 2'b00} +: 4];
    seg_raw   = en_eff ? {dots_pad[digit], seg7(nib)} : 8'h00;
    seg_byte  = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    sel_byte  = 8'd1 << digit;
    frame_new = {seg_byte, sel_byte};
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    frame_d = frame;
    digit_d = digit;
    sclk_d  = sclk;
    sdo_d   = sdo;
    rclk_d  = rclk;
    snap    = 1'b0;
    unique case (state)
      LOAD: begin
        snap    = (digit == 3'd0);
        frame_d = frame_new;
        sdo_d   = frame_new[15];
        cnt_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == 4'd15) begin
              rclk_d  = 1'b1;
              state_d = LATCH;
            end else begin
              bit_d   = bit_cnt + 4'd1;
              frame_d = {frame[14:0], 1'b0};
              sdo_d   = frame[14];
            end
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      LATCH: begin
        if (cnt == DIV_LAST) begin
          cnt_d   = '0;
          rclk_d  = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          digit_d = (digit == DIG_LAST) ? 3'd0 : digit + 3'd1;
          state_d = LOAD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      cnt     <= '0;
      bit_cnt <= '0;
      frame   <= '0;
      hex_sh  <= '0;
      dots_sh <= '0;
      en_sh   <= 1'b0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      rclk    <= 1'b0;
      digit   <= 3'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      frame   <= frame_d;
      sclk    <= sclk_d;
      sdo     <= sdo_d;
      rclk    <= rclk_d;
      digit   <= digit_d;
      if (snap) begin
        hex_sh  <= hex;
        dots_sh <= dots;
        en_sh   <= enable;
      end
    end
  end

endmodule

// File: tb/tb_mfp_hex_serial_display_driver.sv
// Bench for mfp_hex_serial_display_driver: 595-pair model plus a
// frame scoreboard and strobe timing monitor.
module tb_mfp_hex_serial_display_driver;

  localparam int N      = 8;
  localparam int DIV    = 3;
  localparam int HOLDC  = 10;
  localparam int PERIOD = 1 + 33 * DIV + HOLDC;

  logic        clk, rst_n;
  logic [31:0] hex;
  logic [7:0]  dots;
  logic        enable;
  logic        sclk, sdo, rclk;
  logic [2:0]  digit;

  mfp_hex_serial_display_driver #(
    .N_DIGITS(N), .CLK_DIV(DIV), .HOLD_CYCLES(HOLDC), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hex(hex), .dots(dots), .enable(enable),
    .sclk(sclk), .sdo(sdo), .rclk(rclk), .digit(digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    int          dig;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [6:0] segs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                            7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                            7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [31:0] h,
      input logic [7:0] d, input logic en, input int k);
    logic [7:0] seg;
    int nib;
    nib = int'((h >> (4 * k)) & 32'hF);
    seg = en ? {d[k], segs[nib]} : 8'h00;
    seg = ~seg;
    return {seg, 8'(1 << k)};
  endfunction

  task automatic push_scan(input logic [31:0] h, input logic [7:0] d,
                           input logic en);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.frame = model_frame(h, d, en, k);
      e.dig   = k;
      q.push_back(e);
    end
  endtask

  // 595 pair model and strobe timing monitor
  int          cyc = 0;
  int          rises, hi, rhi, last_r;
  logic        pre_s, pre_r, pre_d;
  logic [15:0] sr;
  exp_t        got;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pre_s  = 1'b0;
      pre_r  = 1'b0;
      pre_d  = sdo;
      rises  = 0;
      hi     = 0;
      rhi    = 0;
      last_r = -1;
    end else begin
      if (sclk && !pre_s) begin
        sr = {sr[14:0], sdo};
        rises++;
      end
      if (sclk) begin
        hi++;
        check("sdo_hold_while_sclk_hi", 32'(sdo), 32'(pre_d));
      end
      if (!sclk && pre_s) begin
        check("sclk_high_len", hi, DIV);
        hi = 0;
      end
      if (rclk) rhi++;
      if (!rclk && pre_r) begin
        check("rclk_high_len", rhi, DIV);
        rhi = 0;
      end
      if (rclk && !pre_r) begin
        check("sclk_low_at_latch", 32'(sclk), 0);
        check("sclk_rises_per_frame", rises, 16);
        rises = 0;
        if (last_r >= 0) check("digit_period", cyc - last_r, PERIOD);
        last_r = cyc;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_latch: got %04h want none", sr);
        end else begin
          got = q.pop_front();
          check("latched_frame", 32'(sr), 32'(got.frame));
          check("digit_at_latch", 32'(digit), got.dig);
        end
      end
      pre_s = sclk;
      pre_r = rclk;
      pre_d = sdo;
    end
  end

  logic [31:0] hx [7];
  logic [7:0]  dt [7];
  logic        en [7];

  task automatic apply(input int s);
    hex    = hx[s];
    dots   = dt[s];
    enable = en[s];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sclk"}, 32'(sclk), 0);
    check({tag, "_sdo"}, 32'(sdo), 0);
    check({tag, "_rclk"}, 32'(rclk), 0);
    check({tag, "_digit"}, 32'(digit), 0);
  endtask

  initial begin
    int n, guard;
    logic ps;

    hx[0] = 32'h76543210; dt[0] = 8'h00; en[0] = 1'b1;
    hx[1] = 32'hFEDCBA98; dt[1] = 8'h00; en[1] = 1'b1;
    hx[2] = 32'h11111111; dt[2] = 8'($urandom); en[2] = 1'b1;
    hx[3] = 32'h22222222; dt[3] = 8'($urandom); en[3] = 1'b1;
    hx[4] = $urandom;     dt[4] = 8'($urandom); en[4] = 1'b0;
    hx[5] = $urandom;     dt[5] = 8'($urandom); en[5] = 1'b1;
    hx[6] = $urandom;     dt[6] = 8'($urandom); en[6] = 1'b1;

    rst_n = 1'b0;
    apply(0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    push_scan(hx[0], dt[0], en[0]);
    rst_n = 1'b1;

    // New inputs land mid-scan (digit 3) and must wait for the next scan.
    for (int s = 1; s <= 6; s++) begin
      repeat (380) @(negedge clk);
      apply(s);
      push_scan(hx[s], dt[s], en[s]);
      repeat (500) @(negedge clk);
    end
    repeat (380) @(negedge clk);
    push_scan(hx[6], dt[6], en[6]);
    repeat (500) @(negedge clk);

    n = 0;
    guard = 0;
    ps = sclk;
    while (n < 7 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (sclk && !ps) n++;
      ps = sclk;
    end
    check("seventh_sclk_seen", n, 7);
    rst_n = 1'b0;
    #1;
    check_idle("midframe_reset");
    q.delete();
    hx[0] = $urandom;
    dt[0] = 8'($urandom);
    en[0] = 1'b1;
    apply(0);
    push_scan(hx[0], dt[0], en[0]);
    repeat (3) @(negedge clk);
    check_idle("held_reset");
    rst_n = 1'b1;

    repeat (380) @(negedge clk);
    hx[1] = $urandom;
    dt[1] = 8'($urandom);
    en[1] = 1'b1;
    apply(1);
    push_scan(hx[1], dt[1], en[1]);

    guard = 0;
    while (q.size() > 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
